muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide execution unit that sits beside the ALU in the execute stage.
- Accepts MULT/MULTU/DIV/DIVU requests from the datapath through a start/busy handshake.
- Computes the result over WIDTH cycles and holds it in architectural HI/LO registers.
- Supports direct HI/LO writes (MTHI/MTLO). HI/LO are always visible for MFHI/MFLO.

Parameters:
- WIDTH, 32: operand width. Also the number of iteration cycles per mul/div.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe, sampled on rising edge of clk
- md_op  input  3  0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, 6-7 invalid
- num1  input  WIDTH  multiplicand/dividend; source value for MTHI/MTLO
- num2  input  WIDTH  multiplier/divisor
- busy  output  1  high while a mul/div is iterating
- done  output  1  one-cycle pulse on the cycle after HI/LO receive a mul/div result
- hi  output  WIDTH  HI register: product upper half, or remainder
- lo  output  WIDTH  LO register: product lower half, or quotient
- op_invalid  output  1  one-cycle pulse when start is accepted with md_op 6 or 7

Behaviour:
- Reset (sync, active-high): busy=0, done=0, op_invalid=0, hi=0, lo=0, iteration counter=0. Reset wins over start on the same edge. Reset mid-operation aborts the operation, and no HI/LO update occurs.
- State machine: IDLE, RUN, FINISH.
- IDLE:
  - Start is accepted only in IDLE with busy=0.
  - md_op 0-3: latch operands. Signed ops latch magnitudes plus the sign bits. Load counter=WIDTH and go to RUN. busy=1 from the next cycle.
  - md_op 4: hi<=num1 on the accept edge; stay IDLE, busy stays 0. md_op 5: lo<=num1, same rules.
  - md_op 6-7: op_invalid=1 for the next cycle only; no state change.
- RUN:
  - One shift-add step (multiply) or one restoring-subtract step (divide) per cycle. Counter decrements each cycle.
  - After exactly WIDTH RUN cycles go to FINISH.
- FINISH (one cycle):
  - Apply sign correction and write HI/LO. busy=0 and done=1 on the following cycle; return to IDLE.
- Latency: start accepted at edge E0. busy is high in cycles E0..E0+WIDTH+1 (WIDTH+1 cycles). HI/LO are updated at edge E0+WIDTH+1. done is high for exactly one cycle after that edge.
- A new start may be accepted on the same edge that done is high (back-to-back).
- start while busy=1, any md_op, is ignored: no HI/LO change and no op_invalid. The datapath is responsible for stalling.
- HI/LO hold their value throughout RUN; the old value stays readable until FINISH.
- Multiply: {hi,lo} = full 2*WIDTH-bit product. MULT is two's-complement signed; MULTU is unsigned.
- DIVU: lo=floor(num1/num2), hi=num1 mod num2.
- DIV: quotient truncates toward zero; remainder has the sign of the dividend. Example: -7/2 gives lo=-3, hi=-1.
- Divide by zero:
  - DIVU: lo=all ones, hi=num1.
  - DIV: hi=num1; lo=all ones if num1>=0, else 1.
- DIV overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Operands are captured at accept time. Changes to num1/num2 during RUN have no effect.

Test Plan:
- Reset, then idle 5 cycles -> hi=0, lo=0, busy=0, done=0. Assert reset during RUN of a MULTU -> busy=0 next cycle, hi/lo stay 0, no done pulse.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy high for 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done one cycle. MULT 0xFFFFFFFF*0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero:
  - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
  - DIV 0xFFFFFFFB/0 -> lo=1, hi=0xFFFFFFFB.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated the cycle after each, busy never rises. md_op=7 -> single op_invalid pulse, hi/lo unchanged.
- Start MULTU 3*4. During RUN pulse start with DIVU and with MTHI 0xDEAD -> both ignored, result hi=0, lo=12. Issue a new start on the done cycle -> accepted; busy rises again the next cycle.

Source files
------------

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute-stage datapath and the mul/div unit.
// The datapath drives the request; the unit returns status and the HI/LO registers.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             busy;
    logic             done;
    logic             op_invalid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, md_op, num1, num2,
        input  busy, done, op_invalid, hi, lo
    );

    modport slave (
        input  start, md_op, num1, num2,
        output busy, done, op_invalid, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// It uses one shift-add or restoring-subtract step per cycle on operand magnitudes, then applies sign correction.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave md
);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             done_r;
    logic             inv_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             accept;
    logic             start_md;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        logic signed [WIDTH-1:0] s;
        s = $signed(v);
        return (is_signed && s < 0) ? $unsigned(-s) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m,
                                                    input logic             neg);
        logic signed [WIDTH-1:0] s;
        s = $signed(m);
        return neg ? $unsigned(-s) : m;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] m,
                                                           input logic               neg);
        logic signed [2*WIDTH-1:0] s;
        s = $signed(m);
        return neg ? $unsigned(-s) : m;
    endfunction

    assign accept   = (state == IDLE) && md.start;
    assign start_md = accept && !md.md_op[2];

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opb : '0)};
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
    end

    // Control: FSM, iteration counter, status pulses and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done_r <= 1'b0;
            inv_r  <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
            inv_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (md.md_op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                state <= RUN;
                                cnt   <= CNT_INIT;
                            end
                            3'd4:    hi_r  <= md.num1;
                            3'd5:    lo_r  <= md.num1;
                            default: inv_r <= 1'b1;
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) state <= FINISH;
                end
                FINISH: begin
                    state  <= IDLE;
                    done_r <= 1'b1;
                    if (is_div) begin
                        hi_r <= apply_sign(acc_hi, neg_r);
                        lo_r <= apply_sign(acc_lo, neg_q);
                    end else begin
                        {hi_r, lo_r} <= apply_sign_wide({acc_hi, acc_lo}, neg_q);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: magnitudes in, one iteration step per RUN cycle; no reset needed.
    always_ff @(posedge clk) begin
        if (start_md) begin
            is_div <= md.md_op[1];
            neg_q  <= md.md_op[0] & (md.num1[WIDTH-1] ^ md.num2[WIDTH-1]);
            neg_r  <= md.md_op[0] & md.num1[WIDTH-1];
            opb    <= magnitude(md.num2, md.md_op[0]);
            acc_lo <= magnitude(md.num1, md.md_op[0]);
            acc_hi <= '0;
        end else if (state == RUN) begin
            if (is_div) begin
                if (!div_diff[WIDTH]) begin
                    acc_hi <= div_diff[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    assign md.busy       = (state != IDLE);
    assign md.done       = done_r;
    assign md.op_invalid = inv_r;
    assign md.hi         = hi_r;
    assign md.lo         = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {hi,lo} is queued at issue and compared on each done pulse.
`timescale 1ns/1ps
module tb_muldiv_unit;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(WIDTH)) md ();

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    int          checks    = 0;
    int          errors    = 0;
    int          done_seen = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_pop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] wa, wb;
        logic signed [31:0] da, db, q, r;
        logic [63:0] res;
        res = '0;
        case (op)
            3'd0: res = {32'd0, a} * {32'd0, b};
            3'd1: begin
                wa  = $signed({{32{a[31]}}, a});
                wb  = $signed({{32{b[31]}}, b});
                res = $unsigned(wa * wb);
            end
            3'd2: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            3'd3: begin
                if (b == 0)
                    res = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    res = {32'd0, a};
                else begin
                    da  = $signed(a);
                    db  = $signed(b);
                    q   = da / db;
                    r   = da % db;
                    res = {$unsigned(r), $unsigned(q)};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b0 && md.done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_pop = sb.pop_front();
                check("res_hi", {32'd0, md.hi}, {32'd0, exp_pop[63:32]});
                check("res_lo", {32'd0, md.lo}, {32'd0, exp_pop[31:0]});
            end
        end
    end

    // Issue one mul/div from a negedge, scramble operands during RUN, measure busy and done.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          n;
        logic [31:0] old_hi;
        old_hi    = md.hi;
        md.start  = 1'b1;
        md.md_op  = op;
        md.num1   = a;
        md.num2   = b;
        sb.push_back(model(op, a, b));
        @(negedge clk);
        md.start = 1'b0;
        md.num1  = ~a;
        md.num2  = b + 32'd1;
        check("hold_hi", {32'd0, md.hi}, {32'd0, old_hi});
        n = 0;
        while (md.busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'(WIDTH + 1));
        check("done_pulse", {63'd0, md.done}, 64'd1);
        @(negedge clk);
        check("done_clear", {63'd0, md.done}, 64'd0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (md.done !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(tag, {63'd0, md.done}, 64'd1);
    endtask

    initial begin
        int          t0;
        logic [31:0] old_hi, old_lo;
        md.start = 1'b0;
        md.md_op = 3'd0;
        md.num1  = '0;
        md.num2  = '0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_hi",   {32'd0, md.hi}, 64'd0);
        check("rst_lo",   {32'd0, md.lo}, 64'd0);
        check("rst_busy", {63'd0, md.busy}, 64'd0);
        check("rst_done", {63'd0, md.done}, 64'd0);
        check("rst_inv",  {63'd0, md.op_invalid}, 64'd0);

        // Reset in the middle of a MULTU aborts it.
        t0       = done_seen;
        md.start = 1'b1;
        md.md_op = 3'd0;
        md.num1  = 32'd7;
        md.num2  = 32'd9;
        @(negedge clk);
        md.start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_run", {63'd0, md.busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {63'd0, md.busy}, 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done_seen - t0), 64'd0);
        check("abort_hi", {32'd0, md.hi}, 64'd0);
        check("abort_lo", {32'd0, md.lo}, 64'd0);

        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op(3'd2, 32'd100, 32'd7);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd2, 32'd5, 32'd0);
        run_op(3'd3, 32'hFFFF_FFFB, 32'd0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 6; i++) begin
            run_op(3'($urandom_range(0, 3)), $urandom,
                   (i % 2 == 1) ? 32'($urandom_range(1, 20)) : $urandom);
        end

        // MTHI then MTLO on consecutive cycles.
        md.start = 1'b1;
        md.md_op = 3'd4;
        md.num1  = 32'h1234_5678;
        @(negedge clk);
        check("mthi_hi",   {32'd0, md.hi}, 64'h1234_5678);
        check("mthi_busy", {63'd0, md.busy}, 64'd0);
        md.md_op = 3'd5;
        md.num1  = 32'h9ABC_DEF0;
        @(negedge clk);
        md.start = 1'b0;
        check("mtlo_lo",   {32'd0, md.lo}, 64'h9ABC_DEF0);
        check("mtlo_hi",   {32'd0, md.hi}, 64'h1234_5678);
        check("mtlo_busy", {63'd0, md.busy}, 64'd0);

        // Invalid opcode: one op_invalid pulse, HI/LO untouched.
        md.start = 1'b1;
        md.md_op = 3'd7;
        md.num1  = 32'hFFFF_0000;
        @(negedge clk);
        md.start = 1'b0;
        check("inv_pulse", {63'd0, md.op_invalid}, 64'd1);
        check("inv_hi",    {32'd0, md.hi}, 64'h1234_5678);
        check("inv_lo",    {32'd0, md.lo}, 64'h9ABC_DEF0);
        @(negedge clk);
        check("inv_clear", {63'd0, md.op_invalid}, 64'd0);

        // Starts while busy are ignored; then a back-to-back start on the done cycle.
        md.start = 1'b1;
        md.md_op = 3'd0;
        md.num1  = 32'd3;
        md.num2  = 32'd4;
        sb.push_back(model(3'd0, 32'd3, 32'd4));
        @(negedge clk);
        md.start = 1'b0;
        old_hi   = md.hi;
        old_lo   = md.lo;
        repeat (3) @(negedge clk);
        md.start = 1'b1;
        md.md_op = 3'd2;
        md.num1  = 32'd100;
        md.num2  = 32'd7;
        @(negedge clk);
        check("ign_divu_inv", {63'd0, md.op_invalid}, 64'd0);
        md.md_op = 3'd4;
        md.num1  = 32'h0000_DEAD;
        @(negedge clk);
        check("ign_mthi_hi", {32'd0, md.hi}, {32'd0, old_hi});
        md.md_op = 3'd7;
        @(negedge clk);
        md.start = 1'b0;
        check("ign_lo",  {32'd0, md.lo}, {32'd0, old_lo});
        @(negedge clk);
        check("ign_inv", {63'd0, md.op_invalid}, 64'd0);
        wait_done("b2b_first_done");
        md.start = 1'b1;
        md.md_op = 3'd0;
        md.num1  = 32'd5;
        md.num2  = 32'd6;
        sb.push_back(model(3'd0, 32'd5, 32'd6));
        @(negedge clk);
        md.start = 1'b0;
        check("b2b_busy", {63'd0, md.busy}, 64'd1);
        wait_done("b2b_second_done");
        repeat (2) @(negedge clk);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
